// File: rtl/result_buffer_if.sv
// Producer/consumer bundle for result_buffer: write port, FWFT read port and status.
// Master drives requests and accepts reads; slave is the buffer itself.
interface result_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  logic                     wr_req;
  logic [WIDTH-1:0]         wr_data;
  logic                     wr_last;
  logic                     rd_valid;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_last;
  logic                     rd_ready;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     batch_done;
  logic                     clr_ovf;

  modport master (
    output wr_req, wr_data, wr_last, rd_ready, clr_ovf,
    input  rd_valid, rd_data, rd_last, full, count, overflow, batch_done
  );

  modport slave (
    input  wr_req, wr_data, wr_last, rd_ready, clr_ovf,
    output rd_valid, rd_data, rd_last, full, count, overflow, batch_done
  );
endinterface

// File: rtl/result_buffer.sv
// Circular FWFT buffer of {last, data} words; one-cycle write-to-read latency.
// Writes to a full buffer are dropped (sticky overflow) unless a pop frees a slot that cycle.
module result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  result_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            batch_done_q, batch_done_d;

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [WIDTH:0]  head;

  assign head = mem_q[rd_ptr_q];
  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push = bus.wr_req && (!full || pop);
  assign drop = bus.wr_req && full && !pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    batch_done_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop wins over a simultaneous clear so the lost word is never hidden.
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;

    batch_done_d = pop && head[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      batch_done_q <= batch_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
  end

  assign bus.rd_valid   = (count_q != '0);
  assign bus.rd_data    = head[WIDTH-1:0];
  assign bus.rd_last    = head[WIDTH];
  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.batch_done = batch_done_q;
endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_req  input  1  write request; one-cycle pulse per word from the producing controller.
REQ-006 wr_data  input  WIDTH  word to store; sampled when wr_req=1.
REQ-007 wr_last  input  1  marks the written word as the final word of a batch; sampled with wr_req.
REQ-008 rd_valid  output  1  head entry available.
REQ-009 rd_data  output  WIDTH  head entry data; valid only while rd_valid=1.
REQ-010 rd_last  output  1  last tag of the head entry; valid only while rd_valid=1.
REQ-011 rd_ready  input  1  consumer accepts the head entry when rd_valid=1.
REQ-012 full  output  1  buffer holds DEPTH entries.
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky; a write was dropped.
REQ-015 batch_done  output  1  one-cycle pulse when an entry with last tag is popped.
REQ-016 clr_ovf  input  1  clears overflow.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries, each WIDTH+1 bits ({last, data}), with write pointer, read pointer and count registers.
REQ-018 Read side SHALL be first-word-fall-through: rd_valid = (count != 0); rd_data/rd_last driven from the entry at the read pointer with no added latency.
REQ-019 Pop SHALL occur when rd_valid=1 and rd_ready=1; read pointer advances by 1 modulo DEPTH.
REQ-020 Push SHALL occur when wr_req=1 and (count < DEPTH or a pop occurs in the same cycle); entry written at write pointer, which advances by 1 modulo DEPTH.
REQ-021 A written word SHALL first appear at rd_data in the cycle after the push edge (one-cycle write-to-read latency).
REQ-022 Count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-023 Full with simultaneous wr_req and pop: write SHALL be accepted, count stays DEPTH.
REQ-024 Full, wr_req=1, no pop: word SHALL be dropped, buffer contents and pointers unchanged, overflow set to 1 on that edge.
REQ-025 Empty with wr_req=1 and rd_ready=1: no pop that cycle (rd_valid=0), push occurs, count becomes 1.
REQ-026 rd_ready while empty SHALL have no effect.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of entries.
REQ-028 full = (count == DEPTH), combinational from count.
REQ-029 overflow SHALL stay set until clr_ovf=1 or rst; if clr_ovf and a drop occur in the same cycle, overflow SHALL end set.
REQ-030 batch_done SHALL be a registered pulse, high in the cycle after a pop of an entry with rd_last=1, low otherwise.
REQ-031 Order SHALL be strictly first-in first-out; the last tag travels with its word.

Reset
REQ-032 On a clk edge with rst=1: pointers=0, count=0, overflow=0, batch_done=0; therefore rd_valid=0, full=0.
REQ-033 rst SHALL override any simultaneous wr_req, rd_ready or clr_ovf; no push or pop occurs on that edge.
REQ-034 Storage array contents need no reset; rd_data is don't-care while rd_valid=0.
REQ-035 Reset mid-transfer SHALL discard all stored entries; the first push after reset appears as the new head.

Verification
REQ-036 Fill/drain: DEPTH=8, write 0x0001..0x0008 with rd_ready=0 -> full=1, count=8; then rd_ready=1 -> pops 0x0001..0x0008 in order, count returns to 0.
REQ-037 Overflow: full, write 0xDEAD with rd_ready=0 -> overflow=1, count=8, 0xDEAD never read; clr_ovf pulse -> overflow=0.
REQ-038 Simultaneous: full, wr_req with 0x00AA and rd_ready=1 -> head popped, count stays 8, 0x00AA is read eighth afterwards.
REQ-039 Wrap: 20 push/pop pairs with random data and random rd_ready -> read stream equals write stream, no overflow.
REQ-040 Batch tag: write 3 words, third with wr_last=1; drain -> rd_last=1 only on third word, batch_done high exactly one cycle after its pop.
REQ-041 Reset mid-operation: count=5, assert rst for one edge together with wr_req -> count=0, rd_valid=0, overflow=0; next write appears at rd_data the following cycle.
